// File: rtl/reg_write_arbiter_pkg.sv
// Shared widths, FSM state encoding and helpers for the register-file write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_write_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam int STARVE_W   = 4;

  typedef enum logic [0:0] {
    WB_PRI   = 1'b0,
    MC_FORCE = 1'b1
  } arb_state_e;

  // One-hot mask selecting a single architectural register.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] idx);
    reg_onehot      = '0;
    reg_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bus between the write requesters (WB pipeline, multicycle unit) and the arbiter,
// including the RF write port and the scoreboard issue/query signals.
// The arbiter side uses the slave modport; requesters/environment use master.
interface reg_write_arbiter_if;
  import reg_write_arb_pkg::*;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0]     wb_val;

  logic                  mc_valid;
  logic                  mc_ready;
  logic [REG_ADDR_W-1:0] mc_dest;
  logic [DATA_W-1:0]     mc_val;

  logic                  rf_write_en;
  logic [REG_ADDR_W-1:0] rf_dest;
  logic [DATA_W-1:0]     rf_write_val;

  logic                  mc_issue;
  logic [REG_ADDR_W-1:0] mc_issue_dest;

  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  hazard;
  logic [NUM_REGS-1:0]   busy_mask;

  modport master (
    output wb_valid, wb_dest, wb_val,
    output mc_valid, mc_dest, mc_val,
    output mc_issue, mc_issue_dest, src1, src2,
    input  wb_ready, mc_ready,
    input  rf_write_en, rf_dest, rf_write_val,
    input  hazard, busy_mask
  );

  modport slave (
    input  wb_valid, wb_dest, wb_val,
    input  mc_valid, mc_dest, mc_val,
    input  mc_issue, mc_issue_dest, src1, src2,
    output wb_ready, mc_ready,
    output rf_write_en, rf_dest, rf_write_val,
    output hazard, busy_mask
  );

endinterface

// File: rtl/reg_write_arbiter_scoreboard.sv
// Busy-register scoreboard: tracks registers awaiting a multicycle result.
// Latency: set/clear take effect at the next edge; hazard is combinational from state.
// Backpressure: none; set wins over a same-cycle clear, register 0 is never busy.
module reg_scoreboard
  import reg_write_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_set_vld,
  input  logic [REG_ADDR_W-1:0] i_set_idx,
  input  logic                  i_clr_vld,
  input  logic [REG_ADDR_W-1:0] i_clr_idx,
  input  logic [REG_ADDR_W-1:0] i_src1,
  input  logic [REG_ADDR_W-1:0] i_src2,
  output logic [NUM_REGS-1:0]   o_busy_mask,
  output logic                  o_hazard
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Next busy state: clear first, then set, so a same-cycle set dominates.
  always_comb begin
    w_set_mask    = (i_set_vld && (i_set_idx != '0)) ? reg_onehot(i_set_idx) : '0;
    w_clr_mask    = i_clr_vld ? reg_onehot(i_clr_idx) : '0;
    w_busy_nxt    = (r_busy & ~w_clr_mask) | w_set_mask;
    w_busy_nxt[0] = 1'b0;
  end

  // Busy-bit storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy_mask = r_busy;
  assign o_hazard    = r_busy[i_src1] | r_busy[i_src2];

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates WB and multicycle writes onto one RF write port; WB has priority with MC anti-starvation.
// Latency: a write accepted in cycle N is driven on the RF port in cycle N+1 for one cycle.
// Backpressure: valid/ready; MC stalls behind WB until STARVE_LIMIT losses force one MC grant.
// Optional scoreboard enabled by macro REG_WRITE_ARB_SCOREBOARD_EN (otherwise busy_mask/hazard read 0).
module reg_write_arbiter
  import reg_write_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst,
  reg_write_arbiter_if.slave bus
);

  arb_state_e            r_state;
  logic [STARVE_W-1:0]   r_starve_cnt;
  logic [STARVE_W-1:0]   w_starve_inc;

  logic                  w_wb_rdy;
  logic                  w_mc_rdy;
  logic                  w_wb_acc;
  logic                  w_mc_acc;
  logic                  w_acc;
  logic [REG_ADDR_W-1:0] w_sel_dest;
  logic [DATA_W-1:0]     w_sel_val;

  logic                  r_rf_write_en;
  logic [REG_ADDR_W-1:0] r_rf_dest;
  logic [DATA_W-1:0]     r_rf_write_val;

  logic [NUM_REGS-1:0]   w_busy_mask;
  logic                  w_hazard;

  // Ready generation: both requesters are held off while reset is asserted.
  always_comb begin
    w_wb_rdy = 1'b0;
    w_mc_rdy = 1'b0;
    if (rst) begin
      case (r_state)
        WB_PRI: begin
          w_wb_rdy = 1'b1;
          w_mc_rdy = !bus.wb_valid;
        end
        MC_FORCE: begin
          w_wb_rdy = 1'b0;
          w_mc_rdy = 1'b1;
        end
        default: begin
          w_wb_rdy = 1'b0;
          w_mc_rdy = 1'b0;
        end
      endcase
    end
  end

  // The ready rules above never grant both requesters in the same cycle.
  assign w_wb_acc     = bus.wb_valid & w_wb_rdy;
  assign w_mc_acc     = bus.mc_valid & w_mc_rdy;
  assign w_acc        = w_wb_acc | w_mc_acc;
  assign w_sel_dest   = w_wb_acc ? bus.wb_dest : bus.mc_dest;
  assign w_sel_val    = w_wb_acc ? bus.wb_val  : bus.mc_val;
  assign w_starve_inc = r_starve_cnt + 1'b1;

  // Arbitration FSM with starve counter; MC_FORCE lasts exactly one cycle (grant or withdrawal).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= WB_PRI;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        WB_PRI: begin
          if (w_mc_acc) begin
            r_starve_cnt <= '0;
          end else if (bus.wb_valid && bus.mc_valid) begin
            r_starve_cnt <= w_starve_inc;
            if (w_starve_inc == STARVE_W'(STARVE_LIMIT)) begin
              r_state <= MC_FORCE;
            end
          end
        end
        MC_FORCE: begin
          r_state      <= WB_PRI;
          r_starve_cnt <= '0;
        end
        default: begin
          r_state      <= WB_PRI;
          r_starve_cnt <= '0;
        end
      endcase
    end
  end

  // RF write port: one-cycle pulse after acceptance; writes to register 0 are swallowed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_write_en  <= 1'b0;
      r_rf_dest      <= '0;
      r_rf_write_val <= '0;
    end else begin
      r_rf_write_en <= w_acc && (w_sel_dest != '0);
      if (w_acc && (w_sel_dest != '0)) begin
        r_rf_dest      <= w_sel_dest;
        r_rf_write_val <= w_sel_val;
      end
    end
  end

`ifdef REG_WRITE_ARB_SCOREBOARD_EN
  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_set_vld   (bus.mc_issue),
    .i_set_idx   (bus.mc_issue_dest),
    .i_clr_vld   (w_mc_acc),
    .i_clr_idx   (bus.mc_dest),
    .i_src1      (bus.src1),
    .i_src2      (bus.src2),
    .o_busy_mask (w_busy_mask),
    .o_hazard    (w_hazard)
  );
`else
  logic w_unused_sb;
  assign w_unused_sb = ^{bus.mc_issue, bus.mc_issue_dest, bus.src1, bus.src2};
  assign w_busy_mask = '0;
  assign w_hazard    = 1'b0;
`endif

  assign bus.wb_ready     = w_wb_rdy;
  assign bus.mc_ready     = w_mc_rdy;
  assign bus.rf_write_en  = r_rf_write_en;
  assign bus.rf_dest      = r_rf_dest;
  assign bus.rf_write_val = r_rf_write_val;
  assign bus.busy_mask    = w_busy_mask;
  assign bus.hazard       = w_hazard;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter (STARVE_LIMIT = 4).
// Scoreboard expectations follow REG_WRITE_ARB_SCOREBOARD_EN; without it they are all zero.
module tb_reg_write_arbiter;

`ifdef REG_WRITE_ARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  reg_write_arbiter_if bus_if ();

  reg_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b0;
    bus_if.wb_valid      = 1'b1;
    bus_if.wb_dest       = 5'd0;
    bus_if.wb_val        = 32'h0;
    bus_if.mc_valid      = 1'b1;
    bus_if.mc_dest       = 5'd0;
    bus_if.mc_val        = 32'h0;
    bus_if.mc_issue      = 1'b0;
    bus_if.mc_issue_dest = 5'd0;
    bus_if.src1          = 5'd7;
    bus_if.src2          = 5'd9;

    // Reset state, with requesters asserting valid.
    step();
    step();
    check("rst_wb_ready", bus_if.wb_ready, 0);
    check("rst_mc_ready", bus_if.mc_ready, 0);
    check("rst_rf_en", bus_if.rf_write_en, 0);
    check("rst_rf_dest", bus_if.rf_dest, 0);
    check("rst_rf_val", bus_if.rf_write_val, 0);
    check("rst_busy", bus_if.busy_mask, 0);
    check("rst_hazard", bus_if.hazard, 0);

    // WB-only write accepted in the first cycle after release.
    bus_if.mc_valid = 1'b0;
    rst = 1'b1;
    bus_if.wb_dest = 5'd3;
    bus_if.wb_val  = 32'hDEADBEEF;
    #1;
    check("wb1_wb_ready", bus_if.wb_ready, 1);
    check("wb1_mc_ready", bus_if.mc_ready, 0);
    step();
    bus_if.wb_valid = 1'b0;
    check("wb1_en", bus_if.rf_write_en, 1);
    check("wb1_dest", bus_if.rf_dest, 3);
    check("wb1_val", bus_if.rf_write_val, 32'hDEADBEEF);
    step();
    check("wb1_en_n2", bus_if.rf_write_en, 0);
    check("wb1_dest_hold", bus_if.rf_dest, 3);
    check("wb1_val_hold", bus_if.rf_write_val, 32'hDEADBEEF);

    // MC-only write while WB is idle.
    bus_if.mc_valid = 1'b1;
    bus_if.mc_dest  = 5'd5;
    bus_if.mc_val   = 32'h00000055;
    #1;
    check("mc1_ready", bus_if.mc_ready, 1);
    step();
    bus_if.mc_valid = 1'b0;
    check("mc1_en", bus_if.rf_write_en, 1);
    check("mc1_dest", bus_if.rf_dest, 5);
    check("mc1_val", bus_if.rf_write_val, 32'h00000055);

    // Contention: WB wins four cycles, then MC is forced, then WB resumes.
    bus_if.wb_valid = 1'b1;
    bus_if.wb_dest  = 5'd4;
    bus_if.wb_val   = 32'hA0A00004;
    bus_if.mc_valid = 1'b1;
    bus_if.mc_dest  = 5'd6;
    bus_if.mc_val   = 32'hC0DE0006;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_wb_ready", bus_if.wb_ready, 1);
      check("cont_mc_ready", bus_if.mc_ready, 0);
      step();
      check("cont_wb_dest", bus_if.rf_dest, 4);
    end
    #1;
    check("force_wb_ready", bus_if.wb_ready, 0);
    check("force_mc_ready", bus_if.mc_ready, 1);
    step();
    bus_if.mc_valid = 1'b0;
    check("force_mc_en", bus_if.rf_write_en, 1);
    check("force_mc_dest", bus_if.rf_dest, 6);
    check("force_mc_val", bus_if.rf_write_val, 32'hC0DE0006);
    check("resume_wb_ready", bus_if.wb_ready, 1);
    step();
    bus_if.wb_valid = 1'b0;
    check("resume_wb_dest", bus_if.rf_dest, 4);
    step();
    check("resume_idle_en", bus_if.rf_write_en, 0);

    // Async reset in MC_FORCE with the forced MC write pending.
    bus_if.wb_valid = 1'b1;
    bus_if.mc_valid = 1'b1;
    repeat (4) step();
    check("ar_pre_wb_ready", bus_if.wb_ready, 0);
    #2;
    rst = 1'b0;
    #1;
    check("ar_wb_ready", bus_if.wb_ready, 0);
    check("ar_mc_ready", bus_if.mc_ready, 0);
    check("ar_rf_en", bus_if.rf_write_en, 0);
    check("ar_rf_dest", bus_if.rf_dest, 0);
    check("ar_rf_val", bus_if.rf_write_val, 0);
    step();
    check("ar_dropped_en", bus_if.rf_write_en, 0);
    rst = 1'b1;
    #1;
    check("ar_post_wb_ready", bus_if.wb_ready, 1);
    check("ar_post_mc_ready", bus_if.mc_ready, 0);

    // Counter restarts from zero; then MC withdraws during MC_FORCE.
    repeat (3) step();
    check("ar_cnt_wb_ready", bus_if.wb_ready, 1);
    step();
    check("wd_mc_ready", bus_if.mc_ready, 1);
    bus_if.mc_valid = 1'b0;
    #1;
    check("wd_wb_ready", bus_if.wb_ready, 0);
    step();
    check("wd_no_write", bus_if.rf_write_en, 0);
    check("wd_back_wb_ready", bus_if.wb_ready, 1);
    step();
    bus_if.wb_valid = 1'b0;
    check("wd_wb_en", bus_if.rf_write_en, 1);
    check("wd_wb_dest", bus_if.rf_dest, 4);

    // Destination 0: consumed but not written.
    bus_if.wb_valid = 1'b1;
    bus_if.wb_dest  = 5'd0;
    bus_if.wb_val   = 32'h00001234;
    #1;
    check("d0_wb_ready", bus_if.wb_ready, 1);
    step();
    bus_if.wb_valid = 1'b0;
    check("d0_en", bus_if.rf_write_en, 0);
    check("d0_val_hold", bus_if.rf_write_val, 32'hA0A00004);
    step();
    check("d0_en_n2", bus_if.rf_write_en, 0);

    // Scoreboard: issue r7, hazard on src1, cleared by MC write of r7.
    bus_if.src1          = 5'd7;
    bus_if.src2          = 5'd0;
    bus_if.mc_issue      = 1'b1;
    bus_if.mc_issue_dest = 5'd7;
    step();
    bus_if.mc_issue = 1'b0;
    #1;
    check("sb7_busy", bus_if.busy_mask, SB ? 32'h00000080 : 32'h0);
    check("sb7_hazard", bus_if.hazard, SB ? 1 : 0);
    bus_if.mc_valid = 1'b1;
    bus_if.mc_dest  = 5'd7;
    bus_if.mc_val   = 32'h00000077;
    #1;
    check("sb7_hazard_acc", bus_if.hazard, SB ? 1 : 0);
    step();
    bus_if.mc_valid = 1'b0;
    check("sb7_clr_hazard", bus_if.hazard, 0);
    check("sb7_clr_busy", bus_if.busy_mask, 0);
    check("sb7_rf_dest", bus_if.rf_dest, 7);

    // Same-cycle set and clear of r9: set wins.
    bus_if.mc_issue      = 1'b1;
    bus_if.mc_issue_dest = 5'd9;
    step();
    check("sb9_set", bus_if.busy_mask, SB ? 32'h00000200 : 32'h0);
    bus_if.mc_valid = 1'b1;
    bus_if.mc_dest  = 5'd9;
    bus_if.mc_val   = 32'h00000099;
    step();
    bus_if.mc_issue = 1'b0;
    bus_if.mc_valid = 1'b0;
    bus_if.src1     = 5'd0;
    bus_if.src2     = 5'd9;
    #1;
    check("sb9_set_wins", bus_if.busy_mask, SB ? 32'h00000200 : 32'h0);
    check("sb9_hazard_src2", bus_if.hazard, SB ? 1 : 0);
    bus_if.mc_valid = 1'b1;
    step();
    bus_if.mc_valid = 1'b0;
    check("sb9_clr", bus_if.busy_mask, 0);

    // Issue to r0 never marks anything busy.
    bus_if.mc_issue      = 1'b1;
    bus_if.mc_issue_dest = 5'd0;
    step();
    bus_if.mc_issue = 1'b0;
    bus_if.src1     = 5'd0;
    bus_if.src2     = 5'd0;
    #1;
    check("sb0_busy", bus_if.busy_mask, 0);
    check("sb0_hazard", bus_if.hazard, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
